// File: rtl/spi_xip_pkg.sv
// Shared types and constants for the SPI execute-in-place read controller.
package spi_xip_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_SHIFT = 3'd2;
  localparam state_t S_HOLD  = 3'd3;
  localparam state_t S_GAP   = 3'd4;

  localparam logic [7:0]  CMD_READ   = 8'h03;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned DATA_BITS  = 32;

  // Flash returns the lowest-addressed byte first; it belongs in the word's low lane.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_xip_if.sv
// SRAM-style request port as presented by the upstream arbiter.
interface spi_xip_if;
  import spi_xip_pkg::*;

  logic                 cs;
  logic                 we;
  logic [31:0]          addr;
  logic [3:0]           byte_en;
  logic [31:0]          di;
  logic [DATA_BITS-1:0] rdata;
  logic                 busy;
  logic                 wr_err;

  modport master (
    output cs, we, addr, byte_en, di,
    input  rdata, busy, wr_err
  );

  modport slave (
    input  cs, we, addr, byte_en, di,
    output rdata, busy, wr_err
  );

endinterface

// File: rtl/spi_xip_sck_gen.sv
// SCK divider: low half then high half, each CLK_DIV clk long, running only while enabled.
module spi_xip_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned    CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sck;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Pulses mark the clk edge at which SCK is about to change level.
  assign o_sck  = r_sck;
  assign o_rise = w_wrap & ~r_sck;
  assign o_fall = w_wrap &  r_sck;

endmodule

// File: rtl/spi_xip.sv
// Read-only XIP controller: each accepted word read becomes one single-lane SPI READ frame.
module spi_xip
  import spi_xip_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CSN_GAP = 2
) (
  input  logic     i_clk,
  input  logic     i_rstn,
  spi_xip_if.slave io_bus,
  output logic     o_spi_sck,
  output logic     o_spi_csn,
  output logic     o_spi_mosi,
  input  logic     i_spi_miso
);

  localparam int unsigned   BW       = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] BIT_DATA = BW'(DATA_BITS);
  localparam logic [15:0]   DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0]   GAP_LAST = 16'(CSN_GAP - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [15:0]             r_tmr;
  logic [BW-1:0]           r_bit;
  logic [FRAME_BITS-1:0]   r_frame;
  logic [DATA_BITS-1:0]    r_rx;
  logic [DATA_BITS-1:0]    r_do;
  logic                    r_busy;
  logic                    r_wr_err;
  logic                    r_csn;

  logic w_rd_acc;
  logic w_wr_acc;
  logic w_tmr_done;
  logic w_sck;
  logic w_rise;
  logic w_fall;
  logic w_unused_bits;

  assign w_rd_acc   = io_bus.cs & ~io_bus.we & ~r_busy;
  assign w_wr_acc   = io_bus.cs &  io_bus.we & ~r_busy;
  assign w_tmr_done = (r_tmr == 16'd0);

  // Only the word address within the 16 MiB flash matters; enables and write data are dropped.
  assign w_unused_bits = ^{io_bus.addr[31:24], io_bus.addr[1:0], io_bus.byte_en, io_bus.di};

  spi_xip_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_en   (r_state == S_SHIFT),
    .o_sck  (w_sck),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_rd_acc)                    w_state_nxt = S_SETUP;
      S_SETUP: if (w_tmr_done)                  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_fall && (r_bit == '0))     w_state_nxt = S_HOLD;
      S_HOLD:  if (w_tmr_done)                  w_state_nxt = S_GAP;
      S_GAP:   if (w_tmr_done)                  w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_tmr    <= '0;
      r_bit    <= '0;
      r_frame  <= '0;
      r_rx     <= '0;
      r_do     <= '0;
      r_busy   <= 1'b0;
      r_wr_err <= 1'b0;
      r_csn    <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_wr_err <= w_wr_acc;

      unique case (r_state)
        S_IDLE: begin
          if (w_rd_acc) begin
            r_frame <= {CMD_READ, io_bus.addr[23:2], 2'b00, {DATA_BITS{1'b0}}};
            r_tmr   <= DIV_LAST;
            r_csn   <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_tmr_done) r_bit <= BIT_LAST;
          else            r_tmr <= r_tmr - 16'd1;
        end
        S_SHIFT: begin
          // Only the trailing DATA_BITS periods carry flash data.
          if (w_rise && (r_bit < BIT_DATA)) r_rx <= {r_rx[DATA_BITS-2:0], i_spi_miso};
          if (w_fall) begin
            r_frame <= {r_frame[FRAME_BITS-2:0], 1'b0};
            r_bit   <= r_bit - BW'(1);
            if (r_bit == '0) r_tmr <= DIV_LAST;
          end
        end
        S_HOLD: begin
          if (w_tmr_done) begin
            r_csn <= 1'b1;
            r_tmr <= GAP_LAST;
          end else begin
            r_tmr <= r_tmr - 16'd1;
          end
        end
        S_GAP: begin
          if (w_tmr_done) r_do  <= bswap32(r_rx);
          else            r_tmr <= r_tmr - 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign io_bus.rdata  = r_do;
  assign io_bus.busy   = r_busy;
  assign io_bus.wr_err = r_wr_err;
  assign o_spi_sck     = w_sck;
  assign o_spi_csn     = r_csn;
  assign o_spi_mosi    = r_frame[FRAME_BITS-1];

endmodule
